// File: rtl/candidate_topk_sorter.sv
// rtl/candidate_topk_sorter.sv - streaming top-K candidate sorter keyed on match score
//
// Keeps the K best {score, theta, phi} samples of a stage sweep in a sorted
// slot array (slot 0 = best). One sample is inserted per cycle with no
// backpressure; equal scores keep arrival order.
//
// Ports:
//   clk, rst                : rising-edge clock, asynchronous active-high reset
//   stage_trigger           : starts a new collection (clears slots, latches K)
//   compare_num             : requested K, clamped to 1..DEPTH
//   score_valid, score,
//   theta, phi              : scored sample stream
//   sweep_done              : current sample is the last of the sweep
//   candidate_angle_buffer  : slot i at [(i+1)*2*ANGLE_W-1 -: 2*ANGLE_W] = {theta, phi}
//   sorted_rdy              : one-cycle pulse when the buffer is final
//   cand_count              : number of valid slots
//   best_score              : score in slot 0 (0 when empty)
//   busy                    : collecting or flushing
module candidate_topk_sorter #(
  parameter int DEPTH   = 10,
  parameter int SCORE_W = 16,
  parameter int ANGLE_W = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stage_trigger,
  input  logic [3:0]                   compare_num,
  input  logic                         score_valid,
  input  logic [SCORE_W-1:0]           score,
  input  logic [ANGLE_W-1:0]           theta,
  input  logic [ANGLE_W-1:0]           phi,
  input  logic                         sweep_done,
  output logic [DEPTH*2*ANGLE_W-1:0]   candidate_angle_buffer,
  output logic                         sorted_rdy,
  output logic [3:0]                   cand_count,
  output logic [SCORE_W-1:0]           best_score,
  output logic                         busy
);

  localparam int ANG2_W = 2 * ANGLE_W;
  localparam int SLOT_W = SCORE_W + ANG2_W;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Each slot is {score, theta, phi}.
  logic [SLOT_W-1:0] slot_q [DEPTH];
  logic [SLOT_W-1:0] slot_d [DEPTH];
  logic [3:0]        count_q, count_d;
  logic [3:0]        k_q;
  logic [3:0]        k_trig;
  logic [3:0]        pos;
  logic              ins_en;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stage_trigger) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: if (sweep_done) state_d = S_FLUSH;
        S_FLUSH:   state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == S_COLLECT) || (state_q == S_FLUSH);
    sorted_rdy = (state_q == S_DONE);
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    if (compare_num == 4'd0) begin
      k_trig = 4'd1;
    end else if (compare_num > DEPTH_C) begin
      k_trig = DEPTH_C;
    end else begin
      k_trig = compare_num;
    end
  end

  // Insertion position: valid slots scoring >= the new sample stay ahead of
  // it, which also gives arrival-order tie breaking.
  always_comb begin
    pos = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((4'(i) < count_q) && (slot_q[i][SLOT_W-1 -: SCORE_W] >= score)) begin
        pos = pos + 4'd1;
      end
    end
  end

  assign ins_en = (state_q == S_COLLECT) && score_valid && !stage_trigger && (pos < k_q);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) == pos) begin
        slot_d[i] = {score, theta, phi};
      end
    end
    // Shift pos..K-2 down one place; whatever sat in slot K-1 falls off.
    for (int i = 1; i < DEPTH; i++) begin
      if ((4'(i) > pos) && (4'(i) < k_q)) begin
        slot_d[i] = slot_q[i-1];
      end
    end
    count_d = (count_q < k_q) ? count_q + 4'd1 : k_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= 4'd0;
      k_q     <= 4'd1;
    end else if (stage_trigger) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= 4'd0;
      k_q     <= k_trig;
    end else if (ins_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q <= count_d;
    end
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    candidate_angle_buffer = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) < count_q) begin
        candidate_angle_buffer[i*ANG2_W +: ANG2_W] = slot_q[i][ANG2_W-1:0];
      end
    end
  end

  assign cand_count = count_q;
  assign best_score = (count_q != 4'd0) ? slot_q[0][SLOT_W-1 -: SCORE_W] : '0;

endmodule
